// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Parametrised register file with optional zero register,
//             write-to-read bypass, optional registered read ports and a
//             per-register pending scoreboard with occupancy counter.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [AW-1:0]         w_reg,
  input  logic [XLEN-1:0]       w_data,
  input  logic [NREAD*AW-1:0]   r_reg,
  output logic [NREAD*XLEN-1:0] r_data,
  output logic [NREAD-1:0]      r_pending,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_reg,
  input  logic                  sb_clr,
  output logic [CW-1:0]         busy_count
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [CW-1:0]    r_count;

  logic             w_wr_en;
  logic [NREGS-1:0] w_set_vec;
  logic [NREGS-1:0] w_clr_vec;
  logic [NREGS-1:0] w_pend_next;
  logic             w_inc;
  logic [1:0]       w_dec;

  // Writes to the hardwired zero register are dropped before they reach storage
  assign w_wr_en = reg_write && !((ZERO_REG != 0) && (w_reg == '0));

  // Next pending vector: clears from writeback/squash, then set overrides them.
  // A write and an sb_clr may retire two different registers in one cycle,
  // so the decrement can be 2 while at most one bit is newly set.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_set_vec[i] = sb_set && (sb_reg == AW'(i));
      w_clr_vec[i] = (reg_write && (w_reg == AW'(i))) ||
                     (sb_clr && (sb_reg == AW'(i)));
    end
    if (ZERO_REG != 0) begin
      w_set_vec[0] = 1'b0;
    end
    w_pend_next = (r_pend & ~w_clr_vec) | w_set_vec;
    w_inc       = |(w_pend_next & ~r_pend);
    w_dec       = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_dec = w_dec + 2'(r_pend[i] & ~w_pend_next[i]);
    end
  end

  // Register storage update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_reg] <= w_data;
    end
  end

  // Scoreboard bits and their population count, tracked incrementally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      r_pend  <= w_pend_next;
      r_count <= r_count + CW'(w_inc) - CW'(w_dec);
    end
  end

  assign busy_count = r_count;

  generate
    for (genvar p = 0; p < NREAD; p++) begin : g_read
      logic [AW-1:0]   w_idx;
      logic [XLEN-1:0] w_rd;
      logic            w_pd;

      assign w_idx = r_reg[p*AW +: AW];
      // Pending is never bypassed: a retiring write still shows pending this cycle
      assign w_pd  = r_pend[w_idx];

      // Array read with optional forwarding; zero register wins over everything
      always_comb begin
        w_rd = r_regs[w_idx];
        if ((BYPASS != 0) && w_wr_en && (w_reg == w_idx)) begin
          w_rd = w_data;
        end
        if ((ZERO_REG != 0) && (w_idx == '0)) begin
          w_rd = '0;
        end
      end

      if (READ_REG != 0) begin : g_rreg
        logic [XLEN-1:0] r_rd;
        logic            r_pd;

        // Output registers give one cycle of read latency
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_rd <= '0;
            r_pd <= 1'b0;
          end else begin
            r_rd <= w_rd;
            r_pd <= w_pd;
          end
        end

        assign r_data[p*XLEN +: XLEN] = r_rd;
        assign r_pending[p]           = r_pd;
      end else begin : g_comb
        assign r_data[p*XLEN +: XLEN] = w_rd;
        assign r_pending[p]           = w_pd;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Directed, table-driven bench for regfile_sb. Three instances
//             share write/scoreboard stimulus: default (bypass, comb read),
//             no-bypass single port, and 4-port registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  w_reg;
  logic [63:0] w_data;
  logic        sb_set;
  logic [4:0]  sb_reg;
  logic        sb_clr;

  logic [9:0]   ra_reg;
  logic [127:0] ra_data;
  logic [1:0]   ra_pend;
  logic [5:0]   ra_busy;

  logic [4:0]   rb_reg;
  logic [63:0]  rb_data;
  logic [0:0]   rb_pend;
  logic [5:0]   rb_busy;

  logic [19:0]  rc_reg;
  logic [255:0] rc_data;
  logic [3:0]   rc_pend;
  logic [5:0]   rc_busy;

  int n_chk;
  int n_err;

  assign rb_reg = ra_reg[4:0];

  regfile_sb u_a (
    .clk(clk), .reset(reset), .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data),
    .r_reg(ra_reg), .r_data(ra_data), .r_pending(ra_pend),
    .sb_set(sb_set), .sb_reg(sb_reg), .sb_clr(sb_clr), .busy_count(ra_busy)
  );

  regfile_sb #(.NREAD(1), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data),
    .r_reg(rb_reg), .r_data(rb_data), .r_pending(rb_pend),
    .sb_set(sb_set), .sb_reg(sb_reg), .sb_clr(sb_clr), .busy_count(rb_busy)
  );

  regfile_sb #(.NREAD(4), .READ_REG(1)) u_c (
    .clk(clk), .reset(reset), .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data),
    .r_reg(rc_reg), .r_data(rc_data), .r_pending(rc_pend),
    .sb_set(sb_set), .sb_reg(sb_reg), .sb_clr(sb_clr), .busy_count(rc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        ss;
    logic [4:0]  sr;
    logic        sc;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        p0;
    logic        p1;
    logic [5:0]  busy;
    logic [63:0] nbd0;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                       input logic ss, input logic [4:0] sr, input logic sc);
    reg_write = we;
    w_reg     = wr;
    w_data    = wd;
    sb_set    = ss;
    sb_reg    = sr;
    sb_clr    = sc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    reset  = 1'b1;
    ra_reg = '0;
    rc_reg = '0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0);

    //               we  wr     wd         ss  sr     sc  ra0    ra1    d0         d1         p0 p1 busy   nbd0
    tbl[0]  = '{1'b1, 5'd0,  64'h1234, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 1'b0, 6'd0, 64'h0};
    tbl[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 1'b0, 6'd0, 64'h0};
    tbl[2]  = '{1'b1, 5'd3,  64'h11,   1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  64'h11, 64'h11, 1'b0, 1'b0, 6'd0, 64'h0};
    tbl[3]  = '{1'b1, 5'd3,  64'h22,   1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  64'h22, 64'h22, 1'b0, 1'b0, 6'd0, 64'h11};
    tbl[4]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  64'h22, 64'h0,  1'b0, 1'b0, 6'd0, 64'h22};
    tbl[5]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd8,  1'b0, 5'd8,  5'd3,  64'h0,  64'h22, 1'b0, 1'b0, 6'd0, 64'h0};
    tbl[6]  = '{1'b1, 5'd8,  64'hAA,   1'b1, 5'd8,  1'b0, 5'd8,  5'd3,  64'hAA, 64'h22, 1'b1, 1'b0, 6'd1, 64'h0};
    tbl[7]  = '{1'b1, 5'd8,  64'hBB,   1'b0, 5'd0,  1'b0, 5'd8,  5'd8,  64'hBB, 64'hBB, 1'b1, 1'b1, 6'd1, 64'hAA};
    tbl[8]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  1'b0, 5'd8,  5'd8,  64'hBB, 64'hBB, 1'b0, 1'b0, 6'd0, 64'hBB};
    tbl[9]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd9,  1'b1, 5'd9,  5'd8,  64'h0,  64'hBB, 1'b0, 1'b0, 6'd0, 64'h0};
    tbl[10] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  1'b1, 5'd9,  5'd8,  64'h0,  64'hBB, 1'b0, 1'b0, 6'd0, 64'h0};
    tbl[11] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  1'b0, 5'd9,  5'd8,  64'h0,  64'hBB, 1'b1, 1'b0, 6'd1, 64'h0};
    tbl[12] = '{1'b1, 5'd9,  64'h99,   1'b1, 5'd10, 1'b0, 5'd9,  5'd10, 64'h99, 64'h0,  1'b1, 1'b0, 6'd1, 64'h0};
    tbl[13] = '{1'b1, 5'd12, 64'h5,    1'b0, 5'd10, 1'b1, 5'd10, 5'd9,  64'h0,  64'h99, 1'b1, 1'b0, 6'd1, 64'h0};
    tbl[14] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd1,  1'b0, 5'd10, 5'd1,  64'h0,  64'h0,  1'b0, 1'b0, 6'd0, 64'h0};
    tbl[15] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd2,  1'b0, 5'd1,  5'd2,  64'h0,  64'h0,  1'b1, 1'b0, 6'd1, 64'h0};
    tbl[16] = '{1'b1, 5'd1,  64'h7,    1'b0, 5'd2,  1'b1, 5'd1,  5'd2,  64'h7,  64'h0,  1'b1, 1'b1, 6'd2, 64'h0};
    tbl[17] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  1'b0, 5'd1,  5'd2,  64'h7,  64'h0,  1'b0, 1'b0, 6'd0, 64'h7};

    // Reset state
    @(negedge clk);
    #1;
    chk("reset busy", 64'(ra_busy), 64'd0);
    chk("reset data", ra_data[63:0], 64'h0);
    chk("reset c data", rc_data[63:0], 64'h0);
    reset = 1'b0;

    // Asynchronous reset in mid-cycle after activity
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b1, 5'd7, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0);
    ra_reg = {5'd7, 5'd5};
    rc_reg = {5'd0, 5'd0, 5'd7, 5'd5};
    #1;
    chk("t1 x5 data", ra_data[63:0], 64'hDEAD_BEEF);
    chk("t1 x7 pend", 64'(ra_pend[1]), 64'd1);
    chk("t1 busy", 64'(ra_busy), 64'd1);
    chk("t1 nb x5", rb_data, 64'hDEAD_BEEF);
    next_cycle();
    #1;
    chk("t1 c x5 data", rc_data[63:0], 64'hDEAD_BEEF);
    chk("t1 c x7 pend", 64'(rc_pend), 64'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("t1 rst x5 data", ra_data[63:0], 64'h0);
    chk("t1 rst pend", 64'(ra_pend), 64'h0);
    chk("t1 rst busy", 64'(ra_busy), 64'd0);
    chk("t1 rst c data", rc_data[63:0], 64'h0);
    chk("t1 rst c pend", 64'(rc_pend), 64'h0);
    @(negedge clk);
    reset  = 1'b0;
    rc_reg = '0;

    // Table-driven combinational-read vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ss, tbl[i].sr, tbl[i].sc);
      ra_reg = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("row%0d d0", i), ra_data[63:0], tbl[i].d0);
      chk($sformatf("row%0d d1", i), ra_data[127:64], tbl[i].d1);
      chk($sformatf("row%0d p0", i), 64'(ra_pend[0]), 64'(tbl[i].p0));
      chk($sformatf("row%0d p1", i), 64'(ra_pend[1]), 64'(tbl[i].p1));
      chk($sformatf("row%0d busy", i), 64'(ra_busy), 64'(tbl[i].busy));
      chk($sformatf("row%0d nb d0", i), rb_data, tbl[i].nbd0);
      chk($sformatf("row%0d nb p0", i), 64'(rb_pend[0]), 64'(tbl[i].p0));
      chk($sformatf("row%0d nb busy", i), 64'(rb_busy), 64'(tbl[i].busy));
      next_cycle();
    end

    // Fill every non-zero register, saturate, then drain
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'(r), 1'b0);
      next_cycle();
    end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0);
    ra_reg = {5'd0, 5'd31};
    #1;
    chk("fill busy", 64'(ra_busy), 64'd31);
    chk("fill x31 pend", 64'(ra_pend), 64'h1);
    chk("fill nb busy", 64'(rb_busy), 64'd31);
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("refill busy", 64'(ra_busy), 64'd31);
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'(r), 1'b1);
      next_cycle();
    end
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 1'b1);
    next_cycle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("drain busy", 64'(ra_busy), 64'd0);
    chk("drain nb busy", 64'(rb_busy), 64'd0);

    // Registered four-port read with a same-edge write on port 1
    @(negedge clk);
    drive(1'b1, 5'd1, 64'd1, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd2, 64'd2, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd3, 64'd3, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive(1'b1, 5'd4, 64'd4, 1'b1, 5'd3, 1'b0);
    next_cycle();
    drive(1'b1, 5'd2, 64'd9, 1'b0, 5'd0, 1'b0);
    rc_reg = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    chk("rr before p0", rc_data[63:0], 64'd0);
    chk("rr before pend", 64'(rc_pend), 64'h0);
    next_cycle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd3, 1'b1);
    rc_reg = '0;
    #1;
    chk("rr p0", rc_data[63:0], 64'd1);
    chk("rr p1 bypass", rc_data[127:64], 64'd9);
    chk("rr p2", rc_data[191:128], 64'd3);
    chk("rr p3", rc_data[255:192], 64'd4);
    chk("rr pend", 64'(rc_pend), 64'h4);
    chk("rr busy", 64'(rc_busy), 64'd1);
    next_cycle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rr after p1", rc_data[127:64], 64'd0);
    chk("rr after p3", rc_data[255:192], 64'd0);
    chk("rr after pend", 64'(rc_pend), 64'h0);
    chk("rr after busy", 64'(rc_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
